// File: rtl/ram_bist.sv
// ram_bist: built-in self test engine for a word-addressed RAM.
// Each pass writes a generated pattern to every address, then reads every
// address back and compares the returned words against an independently
// regenerated copy of the same pattern.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   start, mode, passes      run control, sampled when a run is started
//   addr, rw, data_in,       memory request channel; combinational from
//   in_valid, busy           registered state and busy
//   data_out, out_valid      in-order read responses
//   running, done, phase     run state
//   fail, err_count,         mismatch status for the current run
//   lane_err, first_err_addr
//   pass_count               completed passes (wraps at 255)
module ram_bist #(
  parameter int          ADDR_WIDTH = 23,
  parameter int          DATA_WIDTH = 32,
  parameter int          ERR_WIDTH  = 16,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [7:0]              passes,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    rw,
  output logic [DATA_WIDTH-1:0]   data_in,
  output logic                    in_valid,
  input  logic                    busy,
  input  logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    out_valid,
  output logic                    running,
  output logic                    done,
  output logic                    fail,
  output logic [ERR_WIDTH-1:0]    err_count,
  output logic [DATA_WIDTH/8-1:0] lane_err,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [7:0]              pass_count,
  output logic                    phase
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AXW   = ADDR_WIDTH + 32;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] issue_addr, cmp_addr;
  logic [31:0]           seed, wr_gen, cmp_gen;
  logic [1:0]            mode_q;
  logic [7:0]            passes_q;

  logic                  issue_fire, cmp_fire, wr_last, rd_last, pass_end, stop, start_ok;
  logic [7:0]            pass_next;
  logic [31:0]           seed_next;
  logic [DATA_WIDTH-1:0] cmp_exp, diff;
  logic [BYTES-1:0]      lane_diff;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // An all-zero state would lock xorshift at zero forever.
  function automatic logic [31:0] nonzero(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // The PRBS word is the generator state itself; the generator advances
  // after each word, so word n of a pass is xorshift applied n times to
  // the (nonzero) pass seed.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]            m,
                                                    input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [31:0]           g,
                                                    input logic                  pc0);
    logic [DATA_WIDTH-1:0] w;
    logic [AXW-1:0]        bit_pos;
    w       = '0;
    bit_pos = AXW'(a) % AXW'(DATA_WIDTH);
    case (m)
      2'd0: for (int k = 0; k < LANES; k++) w[32*k +: 32] = g ^ 32'(k);
      2'd1: for (int k = 0; k < LANES; k++) w[32*k +: 32] = 32'(a);
      2'd2: w = DATA_WIDTH'(1) << bit_pos;
      default: w = {BYTES{((a[0] ^ pc0) ? 8'h55 : 8'hAA)}};
    endcase
    return w;
  endfunction

  // Request channel: combinational so a busy cycle simply withholds the strobe.
  assign in_valid = ((state == S_WRITE) || (state == S_READ)) && !busy;
  assign rw       = (state == S_WRITE);
  assign addr     = issue_addr;
  assign data_in  = pattern(mode_q, issue_addr, wr_gen, pass_count[0]);

  assign issue_fire = in_valid;
  assign cmp_fire   = out_valid && ((state == S_READ) || (state == S_DRAIN));
  assign wr_last    = issue_fire && (state == S_WRITE) && (issue_addr == ADDR_LAST);
  assign rd_last    = issue_fire && (state == S_READ) && (issue_addr == ADDR_LAST);
  // With a zero-latency memory the final compare can land in READ, in the
  // same cycle as the final read issue, so the pass may close from READ too.
  assign pass_end   = cmp_fire && (cmp_addr == ADDR_LAST);
  assign pass_next  = pass_count + 8'd1;
  assign seed_next  = seed + 32'd1;
  assign stop       = (passes_q != 8'd0) && (pass_next == passes_q);
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign cmp_exp    = pattern(mode_q, cmp_addr, cmp_gen, pass_count[0]);
  assign diff       = data_out ^ cmp_exp;

  always_comb begin
    lane_diff = '0;
    for (int i = 0; i < BYTES; i++) lane_diff[i] = |diff[8*i +: 8];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WRITE;
      S_WRITE:        if (wr_last) state_nxt = S_READ;
      S_READ, S_DRAIN: begin
        if (pass_end)     state_nxt = stop ? S_DONE : S_WRITE;
        else if (rd_last) state_nxt = S_DRAIN;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      issue_addr     <= '0;
      cmp_addr       <= '0;
      seed           <= SEED;
      wr_gen         <= nonzero(SEED);
      cmp_gen        <= nonzero(SEED);
      mode_q         <= 2'd0;
      passes_q       <= 8'd0;
      running        <= 1'b0;
      done           <= 1'b0;
      phase          <= 1'b0;
      fail           <= 1'b0;
      err_count      <= '0;
      lane_err       <= '0;
      first_err_addr <= '0;
      pass_count     <= 8'd0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == S_WRITE) || (state_nxt == S_READ) || (state_nxt == S_DRAIN);
      done    <= (state_nxt == S_DONE);
      phase   <= (state_nxt == S_READ) || (state_nxt == S_DRAIN);

      // Issue side: the address wraps to zero after the last word by itself.
      if (issue_fire) begin
        issue_addr <= issue_addr + 1'b1;
        if (state == S_WRITE) wr_gen <= xorshift32(wr_gen);
      end
      if (wr_last) begin
        wr_gen   <= nonzero(seed);
        cmp_addr <= '0;
        cmp_gen  <= nonzero(seed);
      end

      // Compare side runs on its own address/generator so reads may be
      // outstanding while responses are still arriving.
      if (cmp_fire) begin
        cmp_addr <= cmp_addr + 1'b1;
        cmp_gen  <= xorshift32(cmp_gen);
        lane_err <= lane_diff;
        if (|lane_diff) begin
          fail      <= 1'b1;
          err_count <= sat_inc(err_count);
          if (err_count == '0) first_err_addr <= cmp_addr;
        end
      end

      if (pass_end) begin
        pass_count <= pass_next;
        seed       <= seed_next;
        wr_gen     <= nonzero(seed_next);
      end

      if (start_ok) begin
        mode_q         <= mode;
        passes_q       <= passes;
        issue_addr     <= '0;
        cmp_addr       <= '0;
        seed           <= SEED;
        wr_gen         <= nonzero(SEED);
        cmp_gen        <= nonzero(SEED);
        fail           <= 1'b0;
        err_count      <= '0;
        lane_err       <= '0;
        first_err_addr <= '0;
        pass_count     <= 8'd0;
      end
    end
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 Parameter ADDR_WIDTH, default 23: memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: memory data width; SHALL be a multiple of 32.
REQ-003 Parameter ERR_WIDTH, default 16: error-counter width.
REQ-004 Parameter SEED, default 32'h1: PRBS seed for pass 0.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse: begin run; honoured only in IDLE or DONE.
REQ-008 mode  in  2  pattern: 0 PRBS, 1 address-as-data, 2 walking-one, 3 checkerboard; sampled at start.
REQ-009 passes  in  8  passes to run, sampled at start; 0 = run until rst.
REQ-010 addr  out  ADDR_WIDTH  memory request address.
REQ-011 rw  out  1  1 = write, 0 = read.
REQ-012 data_in  out  DATA_WIDTH  write data to memory.
REQ-013 in_valid  out  1  request strobe.
REQ-014 busy  in  1  memory cannot accept a request this cycle.
REQ-015 data_out  in  DATA_WIDTH  read data from memory.
REQ-016 out_valid  in  1  data_out valid; responses return in request order.
REQ-017 running  out  1  state is WRITE, READ or DRAIN.
REQ-018 done  out  1  state is DONE.
REQ-019 fail  out  1  sticky: at least one mismatch this run.
REQ-020 err_count  out  ERR_WIDTH  mismatched words this run, saturating.
REQ-021 lane_err  out  DATA_WIDTH/8  per-byte mismatch flags of the last compared word.
REQ-022 first_err_addr  out  ADDR_WIDTH  address of first mismatch this run.
REQ-023 pass_count  out  8  completed passes this run.
REQ-024 phase  out  1  0 = write phase, 1 = read/compare phase.

Function
REQ-025 States: IDLE, WRITE, READ, DRAIN, DONE; all outputs registered except addr/rw/data_in/in_valid, which SHALL be combinational from registered state and busy.
REQ-026 IDLE/DONE + start: clear err_count, fail, lane_err, first_err_addr, pass_count; latch mode and passes; issue address and seed to 0 and SEED; go WRITE.
REQ-027 WRITE, busy=0: in_valid=1, rw=1, addr=issue address, data_in=pattern(issue address); advance address and generator; busy=1 SHALL hold in_valid=0 and all counters.
REQ-028 WRITE, write accepted at address all-ones: issue address to 0, reload write generator, go READ.
REQ-029 READ, busy=0: in_valid=1, rw=0, addr=issue address, advance; read accepted at address all-ones: go DRAIN.
REQ-030 Compare path: independent compare address and generator, both reset at READ entry; each out_valid in READ or DRAIN compares data_out to pattern(compare address) and advances.
REQ-031 out_valid in IDLE, WRITE or DONE SHALL be ignored.
REQ-032 Mismatch: fail=1; err_count+1 unless all-ones; first_err_addr=compare address if err_count was 0; lane_err[i] = byte i differs, updated on every compare.
REQ-033 DRAIN: on compare of address all-ones, pass_count+1 (wraps at 255), seed+1; if passes != 0 and new pass_count == passes go DONE, else go WRITE.
REQ-034 A read issue and an out_valid in the same cycle SHALL both take effect.
REQ-035 PRBS: 32-bit xorshift (x^=x<<13; x^=x>>17; x^=x<<5) from current seed, seed value 0 replaced by 1; word = state replicated DATA_WIDTH/32 times, lane k XOR k.
REQ-036 Address-as-data: address zero-extended to 32 bits, replicated per 32-bit lane.
REQ-037 Walking-one: only bit (address mod DATA_WIDTH) set.
REQ-038 Checkerboard: all bytes 8'hAA if address LSB XOR pass_count LSB = 0, else 8'h55.
REQ-039 Compare generator SHALL produce the same sequence as the write generator within one pass.
REQ-040 phase=0 in WRITE, 1 in READ/DRAIN, 0 otherwise.

Reset
REQ-041 rst SHALL force IDLE, issue/compare addresses 0, seed SEED, all status outputs 0, in_valid=0 in the following cycle, from any state including mid-pass.
REQ-042 start asserted with rst SHALL be ignored.

Verification (ADDR_WIDTH=4, DATA_WIDTH=64, zero-latency model memory)
REQ-043 start, mode=1, passes=1, busy=0 -> 16 writes, 16 reads, done=1, fail=0, pass_count=1.
REQ-044 mode=0, passes=2, memory flips bit 40 at address 5 -> err_count=2, first_err_addr=5, lane_err=8'h20 after that compare, fail=1.
REQ-045 busy random 50%, 3-cycle read latency, mode=2 -> no mismatch, each address written and read exactly once per pass.
REQ-046 mode=3, passes=0, 300 passes -> pass_count wraps 255->0, done stays 0, running stays 1.
REQ-047 rst mid-READ at address 7 -> next cycle in_valid=0, running=0, err_count=0; new start restarts at address 0.
REQ-048 memory stuck-at-0 on all words, ERR_WIDTH=3, 2 passes -> err_count saturates at 7.
